// File: rtl/pe_regfile_mc.sv
// CGRA PE register file: routed inputs, FU write-back, two operand ports, send fan-out.
// Optional REGFILE_BYPASS_EN forwards same-cycle writes to register-mode reads.
module pe_regfile_mc #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int N_IN   = 3,
  parameter int N_OUT  = 3,
  localparam int AW    = $clog2(DEPTH),
  localparam int SW    = $clog2(N_IN + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  input  logic [N_IN-1:0]         in_sel,
  input  logic                    in_we,
  input  logic [AW-1:0]           in_addr,
  input  logic                    wb_en,
  input  logic [AW-1:0]           wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic [SW-1:0]           rd1_src,
  input  logic [AW-1:0]           rd1_addr,
  output logic [DATA_W-1:0]       rd1_data,
  output logic                    rd1_valid,
  input  logic [SW-1:0]           rd2_src,
  input  logic [AW-1:0]           rd2_addr,
  output logic [DATA_W-1:0]       rd2_data,
  output logic                    rd2_valid,
  input  logic [AW-1:0]           send_addr,
  input  logic [N_OUT-1:0]        out_en,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    send_valid,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    sel_err
);

  typedef enum logic {IDLE, SWEEP} state_e;

  localparam bit POW2 = (DEPTH == (1 << AW));

  state_e            state_q;
  logic [AW-1:0]     ptr_q;
  logic              sel_err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;

  logic              sweep;
  logic              sel_1h;
  logic [DATA_W-1:0] sel_word;
  logic              in_ok_a, wb_ok_a, r1_ok_a, r2_ok_a, sd_ok_a;
  logic              wr_in, wr_wb;
  logic [DATA_W-1:0] send_word;

  assign sweep    = (state_q == SWEEP);
  assign clr_busy = sweep;
  assign sel_err  = sel_err_q;

  assign sel_1h = (in_sel != '0) &&
                  ((in_sel & (in_sel - N_IN'(1))) == '0);

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N_IN; k++)
      if (in_sel[k])
        sel_word = sel_word | in_data[k*DATA_W +: DATA_W];
  end

  // Out-of-range addresses only exist when DEPTH is not a power of two
  generate
    if (POW2) begin : g_p2
      assign in_ok_a = 1'b1;
      assign wb_ok_a = 1'b1;
      assign r1_ok_a = 1'b1;
      assign r2_ok_a = 1'b1;
      assign sd_ok_a = 1'b1;
    end else begin : g_np2
      localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
      assign in_ok_a = ({1'b0, in_addr}   < DEPTH_L);
      assign wb_ok_a = ({1'b0, wb_addr}   < DEPTH_L);
      assign r1_ok_a = ({1'b0, rd1_addr}  < DEPTH_L);
      assign r2_ok_a = ({1'b0, rd2_addr}  < DEPTH_L);
      assign sd_ok_a = ({1'b0, send_addr} < DEPTH_L);
    end
  endgenerate

  assign wr_in = in_we && sel_1h && in_ok_a && !sweep;
  assign wr_wb = wb_en && wb_ok_a && !sweep;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      if (in_we && !sel_1h)
        sel_err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
          end
        end
        SWEEP: begin
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == AW'(DEPTH - 1))
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= '0;
    end else if (sweep) begin
      vld_q[ptr_q] <= 1'b0;
    end else begin
      if (wr_in) vld_q[in_addr] <= 1'b1;
      if (wr_wb) vld_q[wb_addr] <= 1'b1;
    end
  end

  // Data has no reset; write-back is last so it wins a same-address tie
  always_ff @(posedge CLK) begin
    if (sweep) begin
      mem_q[ptr_q] <= '0;
    end else begin
      if (wr_in) mem_q[in_addr] <= sel_word;
      if (wr_wb) mem_q[wb_addr] <= wb_data;
    end
  end

  function automatic logic [DATA_W:0] rd_port(
    input logic [SW-1:0] src,
    input logic [AW-1:0] addr,
    input logic          ok
  );
    logic [DATA_W:0] r;
    r = '0;
    if (src == '0 && ok) begin
      r = {vld_q[addr] && !sweep, mem_q[addr]};
`ifdef REGFILE_BYPASS_EN
      if (wr_wb && wb_addr == addr)
        r = {1'b1, wb_data};
      else if (wr_in && in_addr == addr)
        r = {1'b1, sel_word};
`endif
    end
    for (int k = 0; k < N_IN; k++)
      if (src == SW'(k + 1))
        r = {1'b1, in_data[k*DATA_W +: DATA_W]};
    return r;
  endfunction

  always_comb begin
    {rd1_valid, rd1_data}   = rd_port(rd1_src, rd1_addr, r1_ok_a);
    {rd2_valid, rd2_data}   = rd_port(rd2_src, rd2_addr, r2_ok_a);
    {send_valid, send_word} = rd_port('0, send_addr, sd_ok_a);
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N_OUT; k++)
      if (out_en[k])
        out_data[k*DATA_W +: DATA_W] = send_word;
  end

endmodule

// File: tb/tb_pe_regfile_mc.sv
// Self-checking bench for pe_regfile_mc: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_pe_regfile_mc;

  localparam int DW = 32;
  localparam int D  = 64;
  localparam int NI = 3;
  localparam int NO = 3;
  localparam int AW = 6;
  localparam int SW = 2;

  logic             CLK, RST;
  logic [NI*DW-1:0] in_data;
  logic [NI-1:0]    in_sel;
  logic             in_we;
  logic [AW-1:0]    in_addr;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic [SW-1:0]    rd1_src, rd2_src;
  logic [AW-1:0]    rd1_addr, rd2_addr;
  logic [DW-1:0]    rd1_data, rd2_data;
  logic             rd1_valid, rd2_valid;
  logic [AW-1:0]    send_addr;
  logic [NO-1:0]    out_en;
  logic [NO*DW-1:0] out_data;
  logic             send_valid;
  logic             clr_req, clr_busy, sel_err;

  pe_regfile_mc dut (
    .CLK(CLK), .RST(RST),
    .in_data(in_data), .in_sel(in_sel), .in_we(in_we), .in_addr(in_addr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd1_src(rd1_src), .rd1_addr(rd1_addr),
    .rd1_data(rd1_data), .rd1_valid(rd1_valid),
    .rd2_src(rd2_src), .rd2_addr(rd2_addr),
    .rd2_data(rd2_data), .rd2_valid(rd2_valid),
    .send_addr(send_addr), .out_en(out_en),
    .out_data(out_data), .send_valid(send_valid),
    .clr_req(clr_req), .clr_busy(clr_busy), .sel_err(sel_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_mem [D];
  bit            m_vld [D];
  bit            m_kn  [D];
  bit            m_err;
  bit            m_sweep;
  int            m_ptr;

  function automatic bit onehot(input logic [NI-1:0] s);
    return $countones(s) == 1;
  endfunction

  function automatic logic [DW-1:0] chan(input int k);
    return in_data[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] sel_chan();
    for (int k = 0; k < NI; k++)
      if (in_sel[k]) return chan(k);
    return '0;
  endfunction

  function automatic void m_read(input int src, input int addr,
                                 output logic [DW-1:0] d,
                                 output bit v, output bit kn);
    d = '0; v = 0; kn = 1;
    if (src == 0) begin
      d  = m_mem[addr];
      kn = m_kn[addr];
      v  = m_vld[addr] && !m_sweep;
`ifdef REGFILE_BYPASS_EN
      if (!m_sweep && wb_en && int'(wb_addr) == addr) begin
        d = wb_data; v = 1; kn = 1;
      end else if (!m_sweep && in_we && onehot(in_sel)
                   && int'(in_addr) == addr) begin
        d = sel_chan(); v = 1; kn = 1;
      end
`endif
    end else if (src <= NI) begin
      d = chan(src - 1); v = 1;
    end
  endfunction

  function automatic void model_step();
    if (in_we && !onehot(in_sel)) m_err = 1;
    if (m_sweep) begin
      m_mem[m_ptr] = '0; m_vld[m_ptr] = 0; m_kn[m_ptr] = 1;
      if (m_ptr == D - 1) m_sweep = 0;
      else m_ptr++;
    end else begin
      if (clr_req) begin m_sweep = 1; m_ptr = 0; end
      if (in_we && onehot(in_sel)) begin
        m_mem[in_addr] = sel_chan(); m_vld[in_addr] = 1; m_kn[in_addr] = 1;
      end
      if (wb_en) begin
        m_mem[wb_addr] = wb_data; m_vld[wb_addr] = 1; m_kn[wb_addr] = 1;
      end
    end
  endfunction

  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    in_data = '0; in_sel = '0; in_we = 0; in_addr = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    rd1_src = '0; rd1_addr = '0; rd2_src = '0; rd2_addr = '0;
    send_addr = '0; out_en = '0; clr_req = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #3;
    for (int i = 0; i < D; i++) m_vld[i] = 0;
    m_err = 0; m_sweep = 0; m_ptr = 0;
    RST = 1'b0;
    @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    for (int a = 0; a < D; a++) begin
      rd1_addr = AW'(a); send_addr = AW'(a);
      #1;
      checks += 2;
      if (rd1_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_rd1_valid addr=%0d got=%b exp=0", a, rd1_valid);
      end
      if (send_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_send_valid addr=%0d got=%b exp=0", a, send_valid);
      end
    end
    checks += 2;
    if (clr_busy !== 1'b0) begin
      failures++; $display("FAIL reset_clr_busy got=%b exp=0", clr_busy);
    end
    if (sel_err !== 1'b0) begin
      failures++; $display("FAIL reset_sel_err got=%b exp=0", sel_err);
    end
  endtask

  task automatic test_route_in();
    idle_inputs();
    in_we = 1; in_sel = 3'b010; in_addr = 6'd5;
    in_data = {32'h0, 32'hA5A5_0001, 32'h0};
    cycle();
    idle_inputs();
    rd1_src = '0; rd1_addr = 6'd5;
    #1;
    checks += 2;
    if (rd1_data !== 32'hA5A5_0001) begin
      failures++; $display("FAIL route_in_data got=%h exp=a5a50001", rd1_data);
    end
    if (rd1_valid !== 1'b1) begin
      failures++; $display("FAIL route_in_valid got=%b exp=1", rd1_valid);
    end
  endtask

  task automatic test_collision();
    idle_inputs();
    in_we = 1; in_sel = 3'b001; in_addr = 6'd7; in_data = {64'h0, 32'h1111};
    wb_en = 1; wb_addr = 6'd7; wb_data = 32'h2222;
    cycle();
    idle_inputs();
    rd1_addr = 6'd7;
    #1;
    checks++;
    if (rd1_data !== 32'h2222) begin
      failures++; $display("FAIL collide_same got=%h exp=2222", rd1_data);
    end
    in_we = 1; in_sel = 3'b001; in_addr = 6'd7; in_data = {64'h0, 32'h1111};
    wb_en = 1; wb_addr = 6'd8; wb_data = 32'h2222;
    cycle();
    idle_inputs();
    rd1_addr = 6'd7; rd2_addr = 6'd8;
    #1;
    checks += 3;
    if (rd1_data !== 32'h1111) begin
      failures++; $display("FAIL collide_diff_in got=%h exp=1111", rd1_data);
    end
    if (rd2_data !== 32'h2222) begin
      failures++; $display("FAIL collide_diff_wb got=%h exp=2222", rd2_data);
    end
    if (sel_err !== 1'b0) begin
      failures++; $display("FAIL collide_no_err got=%b exp=0", sel_err);
    end
  endtask

  task automatic test_sel_err();
    idle_inputs();
    in_we = 1; in_sel = 3'b011; in_addr = 6'd5;
    in_data = {32'h3333, 32'h4444, 32'h5555};
    cycle();
    idle_inputs();
    rd1_addr = 6'd5;
    in_data = {32'hBEEF_0003, 32'h0, 32'h0};
    rd2_src = 2'd3;
    #1;
    checks += 4;
    if (rd1_data !== 32'hA5A5_0001) begin
      failures++; $display("FAIL selerr_nowrite got=%h exp=a5a50001", rd1_data);
    end
    if (sel_err !== 1'b1) begin
      failures++; $display("FAIL selerr_flag got=%b exp=1", sel_err);
    end
    if (rd2_data !== 32'hBEEF_0003) begin
      failures++; $display("FAIL bus_read_data got=%h exp=beef0003", rd2_data);
    end
    if (rd2_valid !== 1'b1) begin
      failures++; $display("FAIL bus_read_valid got=%b exp=1", rd2_valid);
    end
    rd2_src = '0; rd2_addr = 6'd40;
    cycle(); cycle();
    checks += 2;
    if (rd2_valid !== 1'b0) begin
      failures++; $display("FAIL unwritten_valid got=%b exp=0", rd2_valid);
    end
    if (sel_err !== 1'b1) begin
      failures++; $display("FAIL selerr_sticky got=%b exp=1", sel_err);
    end
  endtask

  task automatic test_send();
    idle_inputs();
    send_addr = 6'd5; out_en = 3'b101;
    #1;
    checks += 4;
    if (out_data[31:0] !== 32'hA5A5_0001) begin
      failures++; $display("FAIL send_ch0 got=%h exp=a5a50001", out_data[31:0]);
    end
    if (out_data[63:32] !== 32'h0) begin
      failures++; $display("FAIL send_ch1 got=%h exp=0", out_data[63:32]);
    end
    if (out_data[95:64] !== 32'hA5A5_0001) begin
      failures++; $display("FAIL send_ch2 got=%h exp=a5a50001", out_data[95:64]);
    end
    if (send_valid !== 1'b1) begin
      failures++; $display("FAIL send_valid got=%b exp=1", send_valid);
    end
    wb_en = 1; wb_addr = 6'd5; wb_data = 32'hCAFE_F00D;
    #1;
    checks += 2;
`ifdef REGFILE_BYPASS_EN
    if (out_data[31:0] !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL send_bypass_ch0 got=%h exp=cafef00d", out_data[31:0]);
    end
    if (out_data[95:64] !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL send_bypass_ch2 got=%h exp=cafef00d", out_data[95:64]);
    end
`else
    if (out_data[31:0] !== 32'hA5A5_0001) begin
      failures++; $display("FAIL send_nobyp_ch0 got=%h exp=a5a50001", out_data[31:0]);
    end
    if (out_data[95:64] !== 32'hA5A5_0001) begin
      failures++; $display("FAIL send_nobyp_ch2 got=%h exp=a5a50001", out_data[95:64]);
    end
`endif
    cycle();
    idle_inputs();
  endtask

  task automatic test_sweep();
    int busy;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      wb_en = 1; wb_addr = AW'(i); wb_data = 32'h100 + i;
      cycle();
    end
    idle_inputs();
    clr_req = 1;
    cycle();
    clr_req = 0;
    busy = 0;
    while (clr_busy === 1'b1 && busy < 200) begin
      busy++;
      idle_inputs();
      if (busy == 10) begin
        wb_en = 1; wb_addr = 6'd3; wb_data = 32'hDEAD;
      end
      if (busy >= 20 && busy < 25) clr_req = 1;
      rd1_addr = 6'd8;
      #1;
      checks++;
      if (rd1_valid !== 1'b0) begin
        failures++; $display("FAIL sweep_rd_valid cyc=%0d got=%b exp=0", busy, rd1_valid);
      end
      cycle();
    end
    idle_inputs();
    #1;
    checks++;
    if (busy != D) begin
      failures++; $display("FAIL sweep_len got=%0d exp=%0d", busy, D);
    end
    for (int a = 0; a < D; a++) begin
      rd1_addr = AW'(a);
      #1;
      checks += 2;
      if (rd1_valid !== 1'b0) begin
        failures++; $display("FAIL post_sweep_valid addr=%0d got=%b exp=0", a, rd1_valid);
      end
      if (rd1_data !== 32'h0) begin
        failures++; $display("FAIL post_sweep_data addr=%0d got=%h exp=0", a, rd1_data);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    idle_inputs();
    clr_req = 1;
    cycle();
    clr_req = 0;
    cycle(); cycle();
    checks++;
    if (clr_busy !== 1'b1) begin
      failures++; $display("FAIL midsweep_busy got=%b exp=1", clr_busy);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin
      failures++; $display("FAIL midsweep_abort got=%b exp=0", clr_busy);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [DW-1:0] ed, sd;
    bit ev, ek, sv, sk;
    for (int n = 0; n < 600; n++) begin
      in_data = {$urandom, $urandom, $urandom};
      in_we = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) in_sel = NI'($urandom_range(0, 7));
      else in_sel = NI'(1 << $urandom_range(0, NI - 1));
      in_addr = AW'($urandom_range(0, 15));
      wb_en = ($urandom_range(0, 1) == 1);
      wb_addr = AW'($urandom_range(0, 15));
      wb_data = $urandom;
      rd1_src = SW'($urandom_range(0, 3));
      rd1_addr = AW'($urandom_range(0, 15));
      rd2_src = SW'($urandom_range(0, 3));
      rd2_addr = AW'($urandom_range(0, 15));
      send_addr = AW'($urandom_range(0, 15));
      out_en = NO'($urandom_range(0, 7));
      clr_req = ($urandom_range(0, 149) == 0);
      #1;
      m_read(int'(rd1_src), int'(rd1_addr), ed, ev, ek);
      checks++;
      if (rd1_valid !== ev || (ek && rd1_data !== ed)) begin
        failures++;
        $display("FAIL rand_rd1 n=%0d got=%b/%h exp=%b/%h", n, rd1_valid, rd1_data, ev, ed);
      end
      m_read(int'(rd2_src), int'(rd2_addr), ed, ev, ek);
      checks++;
      if (rd2_valid !== ev || (ek && rd2_data !== ed)) begin
        failures++;
        $display("FAIL rand_rd2 n=%0d got=%b/%h exp=%b/%h", n, rd2_valid, rd2_data, ev, ed);
      end
      m_read(0, int'(send_addr), sd, sv, sk);
      checks++;
      if (send_valid !== sv) begin
        failures++; $display("FAIL rand_send_valid n=%0d got=%b exp=%b", n, send_valid, sv);
      end
      for (int k = 0; k < NO; k++) begin
        if (!out_en[k] || sk) begin
          checks++;
          if (out_data[k*DW +: DW] !== (out_en[k] ? sd : 32'h0)) begin
            failures++;
            $display("FAIL rand_out n=%0d ch=%0d got=%h exp=%h", n, k,
                     out_data[k*DW +: DW], out_en[k] ? sd : 32'h0);
          end
        end
      end
      checks += 2;
      if (sel_err !== m_err) begin
        failures++; $display("FAIL rand_sel_err n=%0d got=%b exp=%b", n, sel_err, m_err);
      end
      if (clr_busy !== m_sweep) begin
        failures++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, clr_busy, m_sweep);
      end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b0;
    idle_inputs();
    for (int i = 0; i < D; i++) begin
      m_kn[i] = 0; m_vld[i] = 0; m_mem[i] = '0;
    end
    @(negedge CLK);
    test_reset();
    test_route_in();
    test_collision();
    test_sel_err();
    test_send();
    test_sweep();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
